// File: rtl/rom_load_fifo.sv
// Download write buffer: queues host writes during a ROM download and hands
// them one at a time to a memory writer over a toggle req/ack handshake.
// Tracks the loaded ROM size, flags dropped writes and signals completion.
module rom_load_fifo #(
    parameter int DW    = 16,
    parameter int AW    = 25,
    parameter int DEPTH = 4,
    parameter int SWAP  = 1
) (
    input  logic          CLK_VIDEO,
    input  logic          reset,
    input  logic          download,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic          wait_o,
    output logic          we_req,
    input  logic          we_ack,
    output logic [AW-1:0] wraddr,
    output logic [DW-1:0] dout,
    output logic [AW-1:0] romsz,
    output logic          overflow,
    output logic          done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    state_t        r_state;
    state_t        w_state_next;
    logic          r_we_req;
    logic          r_wait;
    logic [AW-1:0] r_wraddr;
    logic [DW-1:0] r_dout;
    logic [AW-1:0] r_romsz;
    logic          r_overflow;
    logic          r_done;
    logic          r_pending;
    logic          r_dl_prev;

    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_launch;
    logic          w_rise;
    logic          w_fall;
    logic          w_arm;
    logic          w_done_cond;
    logic          w_wait_next;
    logic [EW-1:0] w_head;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic [DW-1:0] w_head_out;
    logic [AW-1:0] w_end;
    logic [AW-1:0] w_romsz_base;

    // Full is judged on the count before any pop in the same cycle.
    assign w_push = wr & download & (r_count < CW'(DEPTH));
    assign w_drop = wr & download & (r_count == CW'(DEPTH));

    assign w_rise = download & ~r_dl_prev;
    assign w_fall = ~download & r_dl_prev;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_addr = w_head[EW-1:DW];
    assign w_head_data = w_head[DW-1:0];

    generate
        if (DW == 16 && SWAP != 0) begin : g_swap
            assign w_head_out = {w_head_data[7:0], w_head_data[15:8]};
        end else begin : g_noswap
            assign w_head_out = w_head_data;
        end
    endgenerate

    // Drain FSM: launch the head when idle, retire it when the ack catches up.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_launch     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (we_ack == r_we_req) begin
                    w_pop        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Occupancy bookkeeping and backpressure / completion conditions.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
        w_wait_next  = (w_count_next >= CW'(DEPTH - 1)) |
                       ((r_state != IDLE) & (r_count >= CW'(DEPTH - 1)));
        w_arm        = r_pending | w_fall;
        w_done_cond  = w_arm & ~download & (r_count == '0) & (r_state == IDLE);
        w_romsz_base = w_rise ? '0 : r_romsz;
        w_end        = addr + AW'(DW / 8);
    end

    // FIFO storage; no reset so it can map onto RAM resources.
    always_ff @(posedge CLK_VIDEO) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {addr, din};
        end
    end

    // Pointers, count, FSM state and the handshake registers.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= IDLE;
            r_we_req <= 1'b0;
            r_wait   <= 1'b0;
            r_wraddr <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_next;
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_launch) begin
                r_wraddr <= w_head_addr;
                r_dout   <= w_head_out;
                r_we_req <= ~r_we_req;
            end
        end
    end

    // ROM size, overflow flag and download-complete pulse.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            r_romsz    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_pending  <= 1'b0;
            r_dl_prev  <= 1'b0;
        end else begin
            r_dl_prev <= download;
            if (w_push && (w_end > w_romsz_base)) r_romsz <= w_end;
            else                                  r_romsz <= w_romsz_base;
            r_overflow <= (w_rise ? 1'b0 : r_overflow) | w_drop;
            r_done     <= w_done_cond;
            r_pending  <= w_rise ? 1'b0 : (w_arm & ~w_done_cond);
        end
    end

    assign wait_o   = r_wait;
    assign we_req   = r_we_req;
    assign wraddr   = r_wraddr;
    assign dout     = r_dout;
    assign romsz    = r_romsz;
    assign overflow = r_overflow;
    assign done     = r_done;

endmodule

// File: tb/tb_rom_load_fifo.sv
// Directed bench for rom_load_fifo with a scoreboard of expected memory writes.
module tb_rom_load_fifo;

    localparam int DW = 16;
    localparam int AW = 25;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          CLK_VIDEO = 1'b0;
    logic          reset;
    logic          download;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          wait_o;
    logic          we_req;
    logic          we_ack;
    logic [AW-1:0] wraddr;
    logic [DW-1:0] dout;
    logic [AW-1:0] romsz;
    logic          overflow;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    logic          prev_req = 1'b0;
    logic          auto_ack = 1'b0;
    logic          have_cur = 1'b0;
    ent_t          cur;
    ent_t          exp_q[$];
    logic [AW-1:0] exp_romsz = '0;

    rom_load_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SWAP(1)) dut (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .download  (download),
        .wr        (wr),
        .addr      (addr),
        .din       (din),
        .wait_o    (wait_o),
        .we_req    (we_req),
        .we_ack    (we_ack),
        .wraddr    (wraddr),
        .dout      (dout),
        .romsz     (romsz),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; then act as the memory writer: check new requests against
    // the scoreboard, check held data while in flight, optionally acknowledge.
    task automatic tick();
        ent_t e;
        @(posedge CLK_VIDEO);
        #1;
        if (done === 1'b1) done_cnt++;
        if (reset) begin
            prev_req = we_req;
            have_cur = 1'b0;
        end else if (we_req !== prev_req) begin
            chk("req_has_expected_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cur = e;
                have_cur = 1'b1;
                chk("wraddr", 32'(wraddr), 32'(e.a));
                chk("dout", 32'(dout), 32'(e.d));
                $display("write addr=0x%0h data=0x%0h", wraddr, dout);
            end
            prev_req = we_req;
        end else if (have_cur && we_req !== we_ack) begin
            chk("wraddr_stable", 32'(wraddr), 32'(cur.a));
            chk("dout_stable", 32'(dout), 32'(cur.d));
        end
        if (auto_ack) we_ack = we_req;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic acc);
        ent_t e;
        logic [AW-1:0] end_a;
        wr = 1'b1;
        addr = a;
        din = d;
        if (acc) begin
            e.a = a;
            e.d = {d[7:0], d[15:8]};
            exp_q.push_back(e);
            end_a = a + AW'(2);
            if (end_a > exp_romsz) exp_romsz = end_a;
        end
        tick();
        wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dut.r_count != 0 || we_req !== we_ack) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_within_budget", 32'(n < 60), 1);
        chk("drain_sb_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        reset = 1'b1;
        download = 1'b0;
        wr = 1'b0;
        addr = '0;
        din = '0;
        we_ack = 1'b0;
        tick();
        tick();
        chk("rst_we_req", 32'(we_req), 0);
        chk("rst_wait", 32'(wait_o), 0);
        chk("rst_wraddr", 32'(wraddr), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_romsz", 32'(romsz), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;
        tick();

        // Single write, minimum latency, byte swap, romsz.
        download = 1'b1;
        tick();
        push(25'h0, 16'h1234, 1'b1);
        chk("lat_req_not_yet", 32'(we_req), 0);
        tick();
        chk("lat_req_toggled", 32'(we_req), 1);
        chk("single_romsz", 32'(romsz), 2);
        we_ack = 1'b1;
        tick();
        chk("single_count_empty", 32'(dut.r_count), 0);
        chk("single_state_idle", 32'(dut.r_state), 0);

        // romsz is a running maximum.
        auto_ack = 1'b1;
        push(25'h100, 16'hA1B2, 1'b1);
        chk("romsz_after_100", 32'(romsz), 32'h102);
        push(25'h010, 16'hC3D4, 1'b1);
        chk("romsz_not_reduced", 32'(romsz), 32'(exp_romsz));
        drain();

        // Push and pop in the same cycle at count 1.
        auto_ack = 1'b0;
        push(25'h020, 16'h0102, 1'b1);
        tick();
        chk("pp_busy_count", 32'(dut.r_count), 1);
        we_ack = we_req;
        push(25'h022, 16'h0304, 1'b1);
        chk("pp_count_unchanged", 32'(dut.r_count), 1);
        auto_ack = 1'b1;
        we_ack = we_req;
        drain();

        // Fill with the writer stalled; fifth write is dropped.
        auto_ack = 1'b0;
        push(25'h200, 16'h1111, 1'b1);
        push(25'h202, 16'h2222, 1'b1);
        chk("wait_after_2", 32'(wait_o), 0);
        push(25'h204, 16'h3333, 1'b1);
        chk("wait_after_3", 32'(wait_o), 1);
        push(25'h206, 16'h4444, 1'b1);
        chk("ovf_before_drop", 32'(overflow), 0);
        push(25'h208, 16'h5555, 1'b0);
        chk("ovf_after_drop", 32'(overflow), 1);
        chk("full_count", 32'(dut.r_count), DEPTH);
        chk("romsz_ignores_drop", 32'(romsz), 32'(exp_romsz));
        auto_ack = 1'b1;
        we_ack = we_req;
        drain();
        chk("wait_after_drain", 32'(wait_o), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Writes outside a download are ignored; empty FIFO gives done at once.
        download = 1'b0;
        push(25'h3000, 16'hFFFF, 1'b0);
        chk("idle_wr_count", 32'(dut.r_count), 0);
        chk("idle_wr_romsz", 32'(romsz), 32'(exp_romsz));
        chk("done_empty_fifo", 32'(done), 1);
        download = 1'b1;
        exp_romsz = '0;
        tick();
        chk("rise_clears_romsz", 32'(romsz), 0);
        chk("rise_clears_ovf", 32'(overflow), 0);
        chk("rise_done_low", 32'(done), 0);

        // Download ends with two entries queued.
        auto_ack = 1'b0;
        push(25'h400, 16'hBEEF, 1'b1);
        push(25'h402, 16'hCAFE, 1'b1);
        download = 1'b0;
        done_cnt = 0;
        tick();
        tick();
        chk("done_not_early", 32'(done), 0);
        we_ack = we_req;
        tick();
        tick();
        we_ack = we_req;
        tick();
        chk("done_at_last_ack", 32'(done), 0);
        tick();
        chk("done_pulse", 32'(done), 1);
        tick();
        chk("done_one_cycle", 32'(done), 0);
        tick();
        tick();
        chk("done_once", 32'(done_cnt), 1);

        // Reset while a request is in flight.
        download = 1'b1;
        tick();
        push(25'h500, 16'h0A0B, 1'b1);
        push(25'h502, 16'h0C0D, 1'b1);
        if (we_req == 1'b0) begin
            we_ack = we_req;
            tick();
            tick();
        end
        chk("busy_before_reset", 32'(dut.r_state), 1);
        chk("req_high_before_reset", 32'(we_req), 1);
        reset = 1'b1;
        we_ack = 1'b0;
        exp_q.delete();
        exp_romsz = '0;
        tick();
        chk("rst_busy_we_req", 32'(we_req), 0);
        chk("rst_busy_state", 32'(dut.r_state), 0);
        chk("rst_busy_count", 32'(dut.r_count), 0);
        chk("rst_busy_romsz", 32'(romsz), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_idle_req", 32'(we_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_load_fifo.md
ROM_LOAD_FIFO -- requirements
Module: rom_load_fifo

Interface
REQ-001 Parameter DW, default 16, download data width in bits; legal values 8 and 16.
REQ-002 Parameter AW, default 25, byte-address width.
REQ-003 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-004 Parameter SWAP, default 1, byte-swap of 16-bit words on output; ignored when DW=8.
REQ-005 CLK_VIDEO  in  1  clock; reset, synchronous, active-high, on CLK_VIDEO.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 download  in  1  high while a host download is in progress.
REQ-008 wr  in  1  single-cycle write strobe from the host.
REQ-009 addr  in  AW  byte address of the write.
REQ-010 din  in  DW  write data.
REQ-011 wait_o  out  1  host backpressure.
REQ-012 we_req  out  1  toggle request to the memory writer.
REQ-013 we_ack  in  1  toggle acknowledge; the request is complete when we_ack equals we_req.
REQ-014 wraddr  out  AW  address of the in-flight write.
REQ-015 dout  out  DW  data of the in-flight write.
REQ-016 romsz  out  AW  highest written address plus DW/8.
REQ-017 overflow  out  1  sticky flag: a write was dropped.
REQ-018 done  out  1  one-cycle pulse when the download is complete.

Function
REQ-019 Push: wr=1, download=1 and count<DEPTH stores {addr, din}; when count=DEPTH the write is dropped and overflow is set.
REQ-020 wr while download=0 is ignored, with no flag.
REQ-021 Push and pop in the same cycle leave count unchanged; "full" is judged on the pre-pop count.
REQ-022 wait_o is registered, and equals 1 when the next-cycle count is at least DEPTH-1 or the FSM is not IDLE with count at least DEPTH-1; it is otherwise 0.
REQ-023 Drain FSM has two states, IDLE and BUSY.
REQ-024 IDLE with count>0: latch the head into wraddr/dout, invert we_req, go to BUSY.
REQ-025 BUSY with we_ack==we_req: pop the head and go to IDLE.
REQ-026 Minimum latency: a push in cycle N toggles we_req in cycle N+1 when the FSM is IDLE.
REQ-027 Throughput: at most one write per two cycles, set by the ack round trip.
REQ-028 wraddr and dout hold stable for the whole of BUSY.
REQ-029 dout equals {din[7:0], din[15:8]} when SWAP=1 and DW=16; otherwise it equals din.
REQ-030 romsz updates at each push to max(romsz, addr+DW/8), with AW-bit wrap-around truncation.
REQ-031 Rising edge of download clears romsz and overflow.
REQ-032 Rising edge of download does not flush FIFO entries or alter we_req.
REQ-033 done pulses for one cycle on the first cycle where download=0, count=0 and the FSM is IDLE following a falling edge of download.
REQ-034 A new rising edge of download before that condition is met cancels the pending done.
REQ-035 FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Reset
REQ-036 reset drives: FIFO empty, FSM IDLE, we_req=0, wait_o=0, wraddr=0, dout=0, romsz=0, overflow=0, done=0, pending-done cleared.
REQ-037 Reset mid-transfer abandons the in-flight request without waiting for we_ack.
REQ-038 The memory writer is reset by the same signal, so we_ack returns to 0.

Verification
REQ-039 DW=16, SWAP=1: push addr 0x000000 with din 0x1234 -> next cycle we_req=1, wraddr=0, dout=0x3412; we_ack=1 -> FIFO empty, romsz=2.
REQ-040 DEPTH=4, we_ack held at 0, five back-to-back pushes -> wait_o=1 by the third push, fifth push dropped, overflow=1, four entries drained in order once ack toggles.
REQ-041 Push 0x100 then 0x010 -> romsz=0x102 and not reduced.
REQ-042 Simultaneous push and pop at count=1 -> count stays 1, data order preserved.
REQ-043 download falls with two entries queued -> done pulses exactly once, one cycle after the second ack is seen, not before.
REQ-044 reset asserted in BUSY -> next cycle we_req=0, FSM IDLE, count=0, romsz=0.
